// File: rtl/adder_pkg.sv
// Shared defaults and types for the arbitrated adder: operand width, requester
// count, id width and the result-slot state encoding.
package adder_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_REQ = 4;
  localparam int ID_W        = (DEF_NUM_REQ > 1) ? $clog2(DEF_NUM_REQ) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage : adder_pkg

// File: rtl/adder_16bit.sv
// Plain modular adder: the carry out of the top bit is discarded, so the sum
// wraps modulo 2^WIDTH.
module adder_16bit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule : adder_16bit

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: scans from ptr_i upward, wrapping at N-1 -> 0, and
// grants the first asserted request. The grant is one-hot or all-zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    logic found;
    int   idx;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/adder_16bit_arbiter.sv
// Several requesters share one adder through a round-robin arbiter; the sum and
// winner id sit in a single-entry result slot with valid/ready handshake.
module adder_16bit_arbiter
  import adder_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic [IDW-1:0]           res_id
);

  slot_state_e      state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     win_id;
  logic [WIDTH-1:0]   win_a, win_b, win_sum;
  logic               can_accept;
  logic               accept;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IDW)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  // The slot can take a new sum when empty, or when its current sum leaves
  // this very cycle; ready is held low while reset is asserted.
  assign can_accept = (state_q == EMPTY) || res_ready;
  assign req_ready  = (can_accept && rst_n) ? grant : '0;
  assign accept     = |req_ready;

  always_comb begin
    win_id = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id = IDW'(i);
        win_a  = req_a[i*WIDTH +: WIDTH];
        win_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder_16bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i   (win_a),
    .b_i   (win_b),
    .sum_o (win_sum)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    id_d     = id_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      sum_d    = win_sum;
      id_d     = win_id;
      rr_ptr_d = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the data registers are reset too because the
  // observable outputs must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      id_q     <= id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;

endmodule : adder_16bit_arbiter

// File: tb/tb_adder_16bit_arbiter.sv
// Directed bench for adder_16bit_arbiter: stimulus pushes hand-computed results
// into a scoreboard, a monitor pops them on every result handshake.
module tb_adder_16bit_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic [1:0]     res_id;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [1:0]   id;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  adder_16bit_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic expect_grant(input string name, input logic [N-1:0] g,
                              input logic [W-1:0] sum, input logic [1:0] id);
    exp_t e;
    @(negedge clk);
    check(name, 32'(req_ready), 32'(g));
    e.sum = sum;
    e.id  = id;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every result handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_result: got sum 0x%0h id %0d, expected none", res_sum, res_id);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_sum", 32'(res_sum), 32'(e.sum));
        check("res_id", 32'(res_id), 32'(e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] fa [N];
    logic [W-1:0] fb [N];
    logic [W-1:0] fs [N];
    fa = '{16'h0100, 16'h1100, 16'h2200, 16'h3300};
    fb = '{16'h0011, 16'h0022, 16'h0033, 16'hF000};
    fs = '{16'h0111, 16'h1122, 16'h2233, 16'h2300};

    // Reset state, with every requester asking: ready must stay zero.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request from requester 2.
    tick();
    set_op(2, 16'h1234, 16'h0001);
    req_valid = 4'b0100;
    expect_grant("single_grant", 4'b0100, 16'h1235, 2'd2);
    tick();

    // Backpressure for 3 cycles while requester 0 waits with a wrapping sum.
    req_valid = 4'b0001;
    set_op(0, 16'hFFFF, 16'h0002);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_sum", 32'(res_sum), 32'h1235);
      check("bp_res_id", 32'(res_id), 32'd2);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    expect_grant("bp_release_grant", 4'b0001, 16'h0001, 2'd0);
    tick();
    req_valid = '0;
    drain("drain_a");
    tick();

    // Reset while a result is held.
    res_ready = 1'b0;
    req_valid = 4'b0010;
    set_op(1, 16'h00AA, 16'h0055);
    expect_grant("pre_reset_grant", 4'b0010, 16'h00FF, 2'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("pre_reset_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("async_rst_valid", 32'(res_valid), 32'd0);
    check("async_rst_sum", 32'(res_sum), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    sb_q.delete();
    for (int i = 0; i < N; i++) set_op(i, fa[i], fb[i]);
    res_ready = 1'b1;
    tick();
    rst_n = 1'b1;

    // Fairness: all requesting, grants 0,1,2,3,0 on consecutive cycles.
    for (int k = 0; k < 5; k++) begin
      expect_grant("fair_grant", 4'(1 << (k % N)), fs[k % N], 2'(k % N));
      tick();
    end
    req_valid = '0;
    drain("drain_b");

    // Pointer wrap: fresh reset, then only 3, then only 1, then all.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1000;
    set_op(3, 16'h0F0F, 16'h1010);
    expect_grant("ptr_grant3", 4'b1000, 16'h1F1F, 2'd3);
    tick();
    req_valid = 4'b0010;
    set_op(1, 16'h7FFF, 16'h0001);
    expect_grant("ptr_grant1", 4'b0010, 16'h8000, 2'd1);
    tick();
    req_valid = 4'b1111;
    set_op(2, 16'h1234, 16'h0001);
    expect_grant("ptr_at_2", 4'b0100, 16'h1235, 2'd2);
    tick();
    req_valid = '0;
    drain("drain_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_adder_16bit_arbiter

// File: doc/adder_16bit_arbiter.md
ADDER_16BIT_ARBITER -- requirements
Module: adder_16bit_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the adder.
REQ-002 SHALL have parameter WIDTH, default 16: operand and sum width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept, at most one bit high.
REQ-007 SHALL have port req_a, input, NUM_REQ*WIDTH bits: packed operand A, requester i at [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b, input, NUM_REQ*WIDTH bits: packed operand B, same packing.
REQ-009 SHALL have port res_valid, output, 1 bit: result register holds a valid sum.
REQ-010 SHALL have port res_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port res_sum, output, WIDTH bits: registered sum.
REQ-012 SHALL have port res_id, output, clog2(NUM_REQ) bits: index of the requester that produced res_sum.

Function
REQ-013 SHALL accept a transfer from requester i when req_valid[i] and req_ready[i] are both high on a rising clk edge.
REQ-014 SHALL drive req_ready combinationally, one-hot or zero, only to the arbitration winner, and only when slot is EMPTY or (FULL and res_ready high).
REQ-015 SHALL arbitrate round-robin: search starts at rr_ptr and wraps NUM_REQ-1 -> 0; first requester with req_valid high wins.
REQ-016 SHALL set rr_ptr to (winner+1) mod NUM_REQ after each accepted transfer and hold it otherwise.
REQ-017 SHALL compute res_sum = (a + b) mod 2^WIDTH; carry discarded, no saturation.
REQ-018 SHALL register sum and winner index on acceptance, giving res_valid one cycle after acceptance (latency 1).
REQ-019 SHALL implement a two-state slot FSM: EMPTY -> FULL on accept; FULL -> EMPTY on res_ready without accept; FULL -> FULL on simultaneous drain and accept (new result loaded).
REQ-020 SHALL hold res_sum, res_id, res_valid stable while res_valid high and res_ready low.
REQ-021 SHALL sustain one result per cycle when res_ready is held high and any req_valid is high.
REQ-022 SHALL ignore req_a/req_b of non-granted requesters; a requester with req_valid high keeps its operands stable until accepted.
REQ-023 SHALL treat res_ready high while EMPTY as no effect.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force res_valid=0, res_sum=0, res_id=0, rr_ptr=0, FSM=EMPTY.
REQ-025 SHALL hold req_ready all-zero while rst_n is low.
REQ-026 SHALL drop any in-flight result on reset mid-operation; no result is replayed after reset release.

Structure
REQ-027 SHALL place WIDTH and NUM_REQ defaults, ID_W, and the slot-state typedef (EMPTY, FULL) in shared package adder_pkg.
REQ-028 SHALL use existing adder_16bit for the addition, fed by the winner's muxed operands.
REQ-029 SHALL factor the round-robin priority logic into one sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-030 Single request: req_valid=4'b0100, a=16'h1234, b=16'h0001 -> req_ready=4'b0100, next cycle res_valid=1, res_sum=16'h1235, res_id=2.
REQ-031 Wrap: a=16'hFFFF, b=16'h0002 from requester 0 -> res_sum=16'h0001, res_id=0.
REQ-032 Fairness: req_valid=4'b1111 held, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 Backpressure: res_ready=0 for 3 cycles after a result -> res_sum/res_id stable, req_ready=0; res_ready=1 -> next grant same cycle, new result next cycle.
REQ-034 Reset mid-operation: rst_n low while res_valid=1 -> res_valid=0 immediately; after release, first grant goes to requester 0 when all request.
REQ-035 Pointer wrap: only requester 3 then only requester 1 requesting -> grants 3 then 1, rr_ptr 0 -> 0 -> 2.
